led_tick_gen: RTL and testbench

- Parametrised, multi-channel successor to the single fixed-rate LED clock divider.
- Each channel has its own runtime-programmable divisor, enable and free-run/one-shot mode.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe.
- Drives LED blink, display multiplex and door/travel timers from the one system clock.

---
 rtl/led_tick_if.sv | 27 ++
 rtl/led_tick_gen.sv | 90 +++++++++
 tb/tb_led_tick_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_tick_if.sv
// Control and status bundle for led_tick_gen: per-channel enables, shared
// divisor/mode write port, sync, and the registered per-channel outputs.
interface led_tick_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SEL_W    = 4
);
  logic [CHANNELS-1:0] ch_en;
  logic                sync;
  logic                wr_en;
  logic [SEL_W-1:0]    wr_sel;
  logic [WIDTH-1:0]    wr_div;
  logic                wr_mode;
  logic [CHANNELS-1:0] div_clk;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] done;

  modport master (
    output ch_en, sync, wr_en, wr_sel, wr_div, wr_mode,
    input  div_clk, tick, done
  );

  modport slave (
    input  ch_en, sync, wr_en, wr_sel, wr_div, wr_mode,
    output div_clk, tick, done
  );
endinterface

// File: rtl/led_tick_gen.sv
// Multi-channel programmable divider: each channel emits a 50%-duty divided
// clock and a one-cycle tick, in free-run or one-shot mode.
module led_tick_gen #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 25000,
  parameter int unsigned SEL_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  led_tick_if.slave  bus
);

  logic [WIDTH-1:0]    cnt_q     [CHANNELS];
  logic [WIDTH-1:0]    cnt_d     [CHANNELS];
  logic [WIDTH-1:0]    div_val_q [CHANNELS];
  logic [WIDTH-1:0]    div_val_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] div_clk_q, div_clk_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] active, wr_hit;

  // An expired one-shot channel stays parked until re-armed.
  always_comb begin
    active = '0;
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      active[i] = bus.ch_en[i] && !(mode_q[i] && done_q[i]);
      wr_hit[i] = bus.wr_en && (int'(bus.wr_sel) == i);
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    div_val_d = div_val_q;
    mode_d    = mode_q;
    div_clk_d = div_clk_q;
    tick_d    = '0;
    done_d    = done_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.sync) begin
        cnt_d[i]     = '0;
        div_clk_d[i] = 1'b0;
        done_d[i]    = 1'b0;
      end else if (active[i]) begin
        // >= so a divisor lowered below the count terminates immediately.
        if (cnt_q[i] >= div_val_q[i]) begin
          cnt_d[i]     = '0;
          tick_d[i]    = 1'b1;
          div_clk_d[i] = ~div_clk_q[i];
          if (mode_q[i]) done_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
      // A write re-arms the channel even if it expires on this same edge.
      if (wr_hit[i]) begin
        div_val_d[i] = bus.wr_div;
        mode_d[i]    = bus.wr_mode;
        done_d[i]    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        div_val_q[i] <= WIDTH'(DEFAULT_DIV);
      end
      mode_q    <= '0;
      div_clk_q <= '0;
      tick_q    <= '0;
      done_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_val_q <= div_val_d;
      mode_q    <= mode_d;
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign bus.div_clk = div_clk_q;
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_led_tick_gen.sv
// Directed bench for led_tick_gen: expected values are queued as stimulus is
// applied and popped against DUT outputs sampled on the falling edge.
module tb_led_tick_gen;

  logic clk;
  logic reset;

  led_tick_if #(.CHANNELS(4), .WIDTH(16), .SEL_W(4)) bus ();

  led_tick_gen #(
    .CHANNELS   (4),
    .WIDTH      (16),
    .DEFAULT_DIV(25000),
    .SEL_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic write_ch(input logic [3:0] sel, input logic [15:0] div, input logic mode,
                          input logic with_sync);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_div  = div;
    bus.wr_mode = mode;
    bus.sync    = with_sync;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.sync  = 1'b0;
  endtask

  // Counts edges until tick[ch] is seen high, bounded by limit.
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tick[ch] !== 1'b1 && n < limit);
  endtask

  int n;
  int first_t[4];
  int n_t[4];
  int hi[4];
  int bad_tick, bad_clk;

  initial begin
    reset       = 1'b1;
    bus.ch_en   = '0;
    bus.sync    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = '0;
    bus.wr_div  = '0;
    bus.wr_mode = 1'b0;
    repeat (3) @(negedge clk);
    push("rst_div_clk", 0); check(32'(bus.div_clk));
    push("rst_tick", 0);    check(32'(bus.tick));
    push("rst_done", 0);    check(32'(bus.done));

    // Divisors 2/0/5/1, aligned by a sync pulse.
    reset     = 1'b0;
    bus.ch_en = 4'hF;
    write_ch(4'd0, 16'd2, 1'b0, 1'b0);
    write_ch(4'd1, 16'd0, 1'b0, 1'b0);
    write_ch(4'd2, 16'd5, 1'b0, 1'b0);
    write_ch(4'd3, 16'd1, 1'b0, 1'b0);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    push("sync_div_clk", 0); check(32'(bus.div_clk));
    push("sync_tick", 0);    check(32'(bus.tick));
    for (int c = 0; c < 4; c++) begin
      first_t[c] = 0; n_t[c] = 0; hi[c] = 0;
    end
    push("first_tick_ch0", 3); push("first_tick_ch1", 1);
    push("first_tick_ch2", 6); push("first_tick_ch3", 2);
    push("ticks24_ch0", 8);    push("ticks24_ch1", 24);
    push("ticks24_ch2", 4);    push("ticks24_ch3", 12);
    push("divclk_hi_ch0", 12); push("divclk_hi_ch1", 12);
    push("divclk_hi_ch2", 12); push("divclk_hi_ch3", 12);
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (bus.tick[c] === 1'b1) begin
          n_t[c]++;
          if (first_t[c] == 0) first_t[c] = j;
        end
        if (bus.div_clk[c] === 1'b1) hi[c]++;
      end
    end
    for (int c = 0; c < 4; c++) check(32'(first_t[c]));
    for (int c = 0; c < 4; c++) check(32'(n_t[c]));
    for (int c = 0; c < 4; c++) check(32'(hi[c]));

    // Default divisor after reset: first tick on the 25001st edge.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push("default_first_tick", 25001);
    wait_tick(0, 26000, n);
    check(32'(n));
    push("default_tick_all", 4'hF);    check(32'(bus.tick));
    push("default_divclk_all", 4'hF);  check(32'(bus.div_clk));
    @(negedge clk);
    push("default_tick_one_cycle", 0); check(32'(bus.tick));

    // ch0 div=9: freeze at cnt=4 for 7 edges; 6 enabled edges remain to tick.
    write_ch(4'd0, 16'd9, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus.ch_en = 4'b1110;
    bad_tick = 0;
    bad_clk  = 0;
    push("gap_ticks", 0);
    push("gap_divclk_high", 0);
    repeat (7) begin
      @(negedge clk);
      if (bus.tick[0] !== 1'b0) bad_tick++;
      if (bus.div_clk[0] !== 1'b0) bad_clk++;
    end
    check(32'(bad_tick));
    check(32'(bad_clk));
    bus.ch_en = 4'hF;
    push("resume_tick_edges", 6);
    wait_tick(0, 20, n);
    check(32'(n));
    push("resume_divclk", 1); check(32'(bus.div_clk[0]));

    // ch1 div=10, lowered to 3 at cnt=8.
    write_ch(4'd1, 16'd10, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    write_ch(4'd1, 16'd3, 1'b0, 1'b0);
    push("lower_write_edge_tick", 0); check(32'(bus.tick[1]));
    @(negedge clk);
    push("lower_next_tick", 1);       check(32'(bus.tick[1]));
    push("lower_period", 4);
    wait_tick(1, 20, n);
    check(32'(n));
    // Out-of-range select must not touch any channel.
    write_ch(4'd7, 16'd0, 1'b1, 1'b0);
    push("bad_sel_ch1_period", 3);
    wait_tick(1, 20, n);
    check(32'(n));
    push("bad_sel_done", 0); check(32'(bus.done));

    // ch2 one-shot div=4.
    write_ch(4'd2, 16'd4, 1'b1, 1'b1);
    push("oneshot_edges", 5);
    wait_tick(2, 20, n);
    check(32'(n));
    push("oneshot_done", 1); check(32'(bus.done[2]));
    bad_tick = 0;
    push("oneshot_no_retick", 0);
    repeat (20) begin
      @(negedge clk);
      if (bus.tick[2] !== 1'b0) bad_tick++;
    end
    check(32'(bad_tick));
    push("oneshot_done_held", 1);   check(32'(bus.done[2]));
    push("oneshot_divclk_held", 1); check(32'(bus.div_clk[2]));
    write_ch(4'd2, 16'd4, 1'b1, 1'b0);
    push("rearm_done_clear", 0);    check(32'(bus.done[2]));
    push("rearm_edges", 5);
    wait_tick(2, 20, n);
    check(32'(n));
    push("rearm_done_set", 1);      check(32'(bus.done[2]));

    // Sync together with a write to ch3 (div=2).
    repeat (3) @(negedge clk);
    write_ch(4'd3, 16'd2, 1'b0, 1'b1);
    push("sync_wr_div_clk", 0); check(32'(bus.div_clk));
    push("sync_wr_tick", 0);    check(32'(bus.tick));
    for (int c = 0; c < 4; c++) begin
      first_t[c] = 0; n_t[c] = 0;
    end
    push("sync_first_ch0", 10); push("sync_first_ch1", 4);
    push("sync_first_ch2", 5);  push("sync_first_ch3", 3);
    push("sync_ticks12_ch3", 4);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (bus.tick[c] === 1'b1) begin
          n_t[c]++;
          if (first_t[c] == 0) first_t[c] = j;
        end
      end
    end
    for (int c = 0; c < 4; c++) check(32'(first_t[c]));
    check(32'(n_t[3]));

    // Reset mid-count restores outputs and the default divisor.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push("midrst_div_clk", 0); check(32'(bus.div_clk));
    push("midrst_tick", 0);    check(32'(bus.tick));
    push("midrst_done", 0);    check(32'(bus.done));
    push("midrst_first_tick", 25001);
    wait_tick(0, 26000, n);
    check(32'(n));
    push("midrst_tick_all", 4'hF); check(32'(bus.tick));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
